// File: rtl/misao_regbank_pkg.sv
// Shared types and slice helpers for the MISA-O management register bank.
package misao_regbank_pkg;

  // Management opcodes; encodings 10..15 are reserved and behave as NOP.
  typedef enum logic [3:0] {
    NOP   = 4'd0,
    LDI   = 4'd1,
    SS    = 4'd2,
    RSS   = 4'd3,
    RRS   = 4'd4,
    RACC  = 4'd5,
    SA    = 4'd6,
    RSA   = 4'd7,
    RSSN  = 4'd8,
    RSANN = 4'd9
  } op_e;

  // Bank rotator control states.
  typedef enum logic {
    IDLE   = 1'b0,
    ROTATE = 1'b1
  } rot_state_e;

  // Link encodings: slice = 4 << link bits.
  localparam int UL   = 0;
  localparam int LK8  = 1;
  localparam int LK16 = 2;

  // Helpers work on a fixed wide vector; callers size-cast the result to W.
  localparam int MAX_W = 256;

  // Slice width in bits for a link code, clamped to the datapath width.
  function automatic int slice_bits(input int link, input int w);
    int s;
    if (link >= 16) s = w;
    else            s = 4 << link;
    if (s > w) s = w;
    return s;
  endfunction

  // Ones in the low slice, zeros above it.
  function automatic logic [MAX_W-1:0] slice_mask(input int link, input int w);
    int s;
    s = slice_bits(link, w);
    return {MAX_W{1'b1}} >> (MAX_W - s);
  endfunction

  // Rotate the low w bits of value right by one slice; identity when slice = w.
  function automatic logic [MAX_W-1:0] rotr_slice(input logic [MAX_W-1:0] value,
                                                  input int link, input int w);
    int               s;
    logic [MAX_W-1:0] full;
    logic [MAX_W-1:0] vm;
    s    = slice_bits(link, w);
    full = {MAX_W{1'b1}} >> (MAX_W - w);
    vm   = value & full;
    return ((vm >> s) | (vm << (w - s))) & full;
  endfunction

endpackage

// File: rtl/misao_bank_rot.sv
// Depth-N ring register: entry-0 load, single-step rotate, and an N-step
// rotate sequencer that reports busy while it runs.
module misao_bank_rot
  import misao_regbank_pkg::*;
#(
  parameter int W  = 16,
  parameter int N  = 2,
  parameter int CW = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [W-1:0]         load_data,
  input  logic                 step,
  input  logic                 start,
  input  logic [CW-1:0]        cnt,
  output logic                 busy,
  output logic [W-1:0]         head,
  input  logic [$clog2(N)-1:0] rd_sel,
  output logic [W-1:0]         rd_data
);

  rot_state_e    state, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          shift;
  logic [W-1:0]  ring [N];

  // Sequencer state and remaining-step counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt_q <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      state <= state_d;
      cnt_q <= cnt_d;
    end
  end

  // Next-state logic: a zero count never leaves IDLE; N > 0 takes N ROTATE cycles.
  always_comb begin
    // NOTE: defaults first so no path leaves a signal unassigned (no latches).
    state_d = state;
    cnt_d   = cnt_q;
    shift   = 1'b0;
    case (state)
      IDLE: begin
        if (start && (cnt != '0)) begin
          state_d = ROTATE;
          cnt_d   = cnt;
        end else if (step) begin
          shift = 1'b1;
        end
      end
      ROTATE: begin
        shift = 1'b1;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Ring storage: rotate down by one, or overwrite entry 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the bank must clear on reset, so it is built from flops, not a RAM.
      for (int i = 0; i < N; i++) ring[i] <= '0;
    end else if (shift) begin
      for (int i = 0; i < N; i++) ring[i] <= ring[(i + 1) % N];
    end else if (load) begin
      ring[0] <= load_data;
    end
  end

  assign busy    = (state == ROTATE);
  assign head    = ring[0];
  assign rd_data = (int'(rd_sel) < N) ? ring[rd_sel] : '0;

endmodule

// File: rtl/misao_regbank.sv
// MISA-O management datapath: ACC plus RS and RA ring banks, executing
// slice-granular management ops and multi-cycle bank rotates.
module misao_regbank
  import misao_regbank_pkg::*;
#(
  parameter int W  = 16,
  parameter int NS = 2,
  parameter int NA = 2,
  parameter int LW = $clog2($clog2(W / 4) + 1),
  parameter int CW = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  op_valid,
  output logic                  op_ready,
  input  logic [3:0]            op_code,
  input  logic [LW-1:0]         link,
  input  logic [W-1:0]          imm,
  input  logic [CW-1:0]         rot_cnt,
  output logic                  busy,
  output logic [W-1:0]          acc,
  output logic [W-1:0]          rs0,
  output logic [W-1:0]          ra0,
  input  logic [$clog2(NS)-1:0] rs_sel,
  output logic [W-1:0]          rs_rd
);

  op_e          op;
  logic         accept;
  logic [W-1:0] mask;
  logic [W-1:0] acc_d;
  logic         rs_load, rs_step, rs_start, rs_busy;
  logic         ra_load, ra_step, ra_start, ra_busy;
  logic [W-1:0] rs_load_data, ra_load_data, ra_head;

  assign op       = op_e'(op_code);
  assign busy     = rs_busy | ra_busy;
  assign op_ready = !busy;
  assign accept   = op_valid && op_ready;

  // Op decode: compute the next ACC and the bank load/step/start controls.
  always_comb begin
    mask         = W'(slice_mask(int'(link), W));
    acc_d        = acc;
    rs_load      = 1'b0;
    rs_load_data = rs0;
    rs_step      = 1'b0;
    rs_start     = 1'b0;
    ra_load      = 1'b0;
    ra_load_data = ra_head;
    ra_step      = 1'b0;
    ra_start     = 1'b0;
    if (accept) begin
      case (op)
        LDI:  acc_d = (acc & ~mask) | (imm & mask);
        SS: begin
          acc_d        = (acc & ~mask) | (rs0 & mask);
          rs_load      = 1'b1;
          rs_load_data = (rs0 & ~mask) | (acc & mask);
        end
        RRS: begin
          rs_load      = 1'b1;
          rs_load_data = W'(rotr_slice(MAX_W'(rs0), int'(link), W));
        end
        RACC: acc_d = W'(rotr_slice(MAX_W'(acc), int'(link), W));
        SA: begin
          acc_d        = ra_head;
          ra_load      = 1'b1;
          ra_load_data = acc;
        end
        RSS:   rs_step  = 1'b1;
        RSA:   ra_step  = 1'b1;
        RSSN:  rs_start = 1'b1;
        RSANN: ra_start = 1'b1;
        default: ;
      endcase
    end
  end

  // Accumulator register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) acc <= '0;
    else      acc <= acc_d;
  end

  misao_bank_rot #(.W(W), .N(NS), .CW(CW)) u_rs (
    .clk       (clk),
    .rst       (rst),
    .load      (rs_load),
    .load_data (rs_load_data),
    .step      (rs_step),
    .start     (rs_start),
    .cnt       (rot_cnt),
    .busy      (rs_busy),
    .head      (rs0),
    .rd_sel    (rs_sel),
    .rd_data   (rs_rd)
  );

  // The RA read port is pinned to entry 0 and drives the ra0 output.
  misao_bank_rot #(.W(W), .N(NA), .CW(CW)) u_ra (
    .clk       (clk),
    .rst       (rst),
    .load      (ra_load),
    .load_data (ra_load_data),
    .step      (ra_step),
    .start     (ra_start),
    .cnt       (rot_cnt),
    .busy      (ra_busy),
    .head      (ra_head),
    .rd_sel    ('0),
    .rd_data   (ra0)
  );

endmodule

// File: tb/tb_misao_regbank.sv
// Bench for misao_regbank (W=16, NS=4, NA=2): table of single-cycle ops checked
// through a scoreboard queue, plus hand sequences for rotates and reset.
module tb_misao_regbank;
  import misao_regbank_pkg::*;

  localparam int W  = 16;
  localparam int NS = 4;
  localparam int NA = 2;
  localparam int LW = 2;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          op_valid;
  logic          op_ready;
  logic [3:0]    op_code;
  logic [LW-1:0] link;
  logic [W-1:0]  imm;
  logic [CW-1:0] rot_cnt;
  logic          busy;
  logic [W-1:0]  acc, rs0, ra0, rs_rd;
  logic [1:0]    rs_sel;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       name;
    logic [3:0]  op;
    int          lnk;
    logic [15:0] imm;
    logic [3:0]  cnt;
    logic [1:0]  sel;
    logic [15:0] acc;
    logic [15:0] rs0;
    logic [15:0] ra0;
    logic [15:0] rd;
  } vec_t;

  typedef struct {
    string       name;
    logic [15:0] acc;
    logic [15:0] rs0;
    logic [15:0] ra0;
    logic [15:0] rd;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[24];

  misao_regbank #(.W(W), .NS(NS), .NA(NA), .CW(CW)) dut (
    .clk      (clk),
    .rst      (rst),
    .op_valid (op_valid),
    .op_ready (op_ready),
    .op_code  (op_code),
    .link     (link),
    .imm      (imm),
    .rot_cnt  (rot_cnt),
    .busy     (busy),
    .acc      (acc),
    .rs0      (rs0),
    .ra0      (ra0),
    .rs_sel   (rs_sel),
    .rs_rd    (rs_rd)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Pop the oldest expectation and compare it against the settled outputs.
  task automatic collect();
    exp_t e;
    @(negedge clk);
    if (sb.size() == 0) begin
      check("scoreboard_empty", 1, 0);
      return;
    end
    e = sb.pop_front();
    check({e.name, ".acc"},  acc,   e.acc);
    check({e.name, ".rs0"},  rs0,   e.rs0);
    check({e.name, ".ra0"},  ra0,   e.ra0);
    check({e.name, ".rd"},   rs_rd, e.rd);
    check({e.name, ".busy"}, busy,  0);
  endtask

  // Drive one single-cycle op and queue its expected result.
  task automatic apply(input vec_t v);
    @(negedge clk);
    op_code  = v.op;
    link     = LW'(v.lnk);
    imm      = v.imm;
    rot_cnt  = v.cnt;
    rs_sel   = v.sel;
    op_valid = 1'b1;
    sb.push_back('{v.name, v.acc, v.rs0, v.ra0, v.rd});
    @(posedge clk);
    #1 op_valid = 1'b0;
    collect();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int  busy_cnt;
    bit  done, ready_ok, acc_hold, seen;

    rst = 1'b0; op_valid = 1'b0; op_code = '0; link = '0; imm = '0;
    rot_cnt = '0; rs_sel = '0;
    #1;
    check("reset.acc", acc, 0);
    check("reset.rs0", rs0, 0);
    check("reset.ra0", ra0, 0);
    check("reset.busy", busy, 0);
    check("reset.ready", op_ready, 1);
    @(negedge clk);
    rst = 1'b1;

    //          name        op     link  imm       cnt sel  acc       rs0       ra0       rd
    tbl[0]  = '{"ldi_ul",   LDI,   UL,   16'h0005, 0,  0,   16'h0005, 16'h0000, 16'h0000, 16'h0000};
    tbl[1]  = '{"ldi_lk8",  LDI,   LK8,  16'h00B3, 0,  0,   16'h00B3, 16'h0000, 16'h0000, 16'h0000};
    tbl[2]  = '{"ldi_lk16", LDI,   LK16, 16'hCAFE, 0,  0,   16'hCAFE, 16'h0000, 16'h0000, 16'h0000};
    tbl[3]  = '{"ldi_keep", LDI,   LK8,  16'h0091, 0,  0,   16'hCA91, 16'h0000, 16'h0000, 16'h0000};
    tbl[4]  = '{"ldi_1357", LDI,   LK16, 16'h1357, 0,  0,   16'h1357, 16'h0000, 16'h0000, 16'h0000};
    tbl[5]  = '{"ss_full",  SS,    LK16, 16'h0000, 0,  0,   16'h0000, 16'h1357, 16'h0000, 16'h1357};
    tbl[6]  = '{"rrs_ul",   RRS,   UL,   16'h0000, 0,  0,   16'h0000, 16'h7135, 16'h0000, 16'h7135};
    tbl[7]  = '{"ldi_a000", LDI,   LK16, 16'hA000, 0,  0,   16'hA000, 16'h7135, 16'h0000, 16'h7135};
    tbl[8]  = '{"ss_back",  SS,    LK16, 16'h0000, 0,  0,   16'h7135, 16'hA000, 16'h0000, 16'hA000};
    tbl[9]  = '{"ldi_d2",   LDI,   LK8,  16'h00D2, 0,  0,   16'h71D2, 16'hA000, 16'h0000, 16'hA000};
    tbl[10] = '{"racc_lk8", RACC,  LK8,  16'h0000, 0,  0,   16'hD271, 16'hA000, 16'h0000, 16'hA000};
    tbl[11] = '{"racc_w",   RACC,  LK16, 16'h0000, 0,  0,   16'hD271, 16'hA000, 16'h0000, 16'hA000};
    tbl[12] = '{"racc_clmp",RACC,  3,    16'h0000, 0,  0,   16'hD271, 16'hA000, 16'h0000, 16'hA000};
    tbl[13] = '{"ss_d271",  SS,    LK16, 16'h0000, 0,  0,   16'hA000, 16'hD271, 16'h0000, 16'hD271};
    tbl[14] = '{"ldi_clmp", LDI,   3,    16'h89A7, 0,  0,   16'h89A7, 16'hD271, 16'h0000, 16'hD271};
    tbl[15] = '{"ss_ul",    SS,    UL,   16'h0000, 0,  0,   16'h89A1, 16'hD277, 16'h0000, 16'hD277};
    tbl[16] = '{"rss",      RSS,   UL,   16'h0000, 0,  3,   16'h89A1, 16'h0000, 16'h0000, 16'hD277};
    tbl[17] = '{"nop",      NOP,   LK16, 16'hFFFF, 0,  3,   16'h89A1, 16'h0000, 16'h0000, 16'hD277};
    tbl[18] = '{"reserved", 4'hF,  LK16, 16'hFFFF, 0,  3,   16'h89A1, 16'h0000, 16'h0000, 16'hD277};
    tbl[19] = '{"ldi_d27c", LDI,   LK16, 16'hD27C, 0,  3,   16'hD27C, 16'h0000, 16'h0000, 16'hD277};
    tbl[20] = '{"sa",       SA,    UL,   16'h0000, 0,  3,   16'h0000, 16'h0000, 16'hD27C, 16'hD277};
    tbl[21] = '{"rsa",      RSA,   UL,   16'h0000, 0,  3,   16'h0000, 16'h0000, 16'h0000, 16'hD277};
    tbl[22] = '{"rsa_back", RSA,   UL,   16'h0000, 0,  3,   16'h0000, 16'h0000, 16'hD27C, 16'hD277};
    tbl[23] = '{"rss_2",    RSS,   UL,   16'h0000, 0,  2,   16'h0000, 16'h0000, 16'hD27C, 16'hD277};

    for (int i = 0; i < 24; i++) apply(tbl[i]);

    // RSANN with a zero count completes like a NOP.
    @(negedge clk);
    op_code = RSANN; rot_cnt = 4'd0; op_valid = 1'b1;
    @(posedge clk);
    #1 op_valid = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (busy) seen = 1'b1;
    end
    check("rsann0.busy_never", seen, 0);
    check("rsann0.ra0", ra0, 16'hD27C);

    // Fresh bank, then fill RS = {1,2,3,4} with LDI / SS / RSS.
    do_reset();
    for (int v = 1; v <= 4; v++) begin
      apply('{$sformatf("fill_ldi%0d", v), LDI, LK16, 16'(v), 0, 0,
              16'(v), 16'h0000, 16'h0000, 16'h0000});
      apply('{$sformatf("fill_ss%0d", v), SS, LK16, 16'h0000, 0, 0,
              16'h0000, 16'(v), 16'h0000, 16'(v)});
      apply('{$sformatf("fill_rss%0d", v), RSS, UL, 16'h0000, 0, 0,
              16'h0000, (v == 4) ? 16'h0001 : 16'h0000, 16'h0000,
              (v == 4) ? 16'h0001 : 16'h0000});
    end

    // RSSN by 3 with an LDI waiting behind it.
    @(negedge clk);
    op_code = RSSN; rot_cnt = 4'd3; rs_sel = 2'd1; op_valid = 1'b1;
    @(posedge clk);
    #1;
    op_code = LDI; link = LW'(LK16); imm = 16'h00AA; op_valid = 1'b1;
    busy_cnt = 0; done = 1'b0; ready_ok = 1'b1; acc_hold = 1'b1;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (op_ready === busy) ready_ok = 1'b0;
      if (busy) begin
        busy_cnt++;
        if (acc !== 16'h0000) acc_hold = 1'b0;
      end else begin
        done = 1'b1;
      end
    end
    check("rssn3.completed", done, 1);
    check("rssn3.busy_cycles", busy_cnt, 3);
    check("rssn3.ready_is_not_busy", ready_ok, 1);
    check("rssn3.acc_held", acc_hold, 1);
    check("rssn3.rs0", rs0, 16'h0004);
    check("rssn3.rs1", rs_rd, 16'h0001);
    check("rssn3.ldi_deferred", acc, 16'h0000);
    @(posedge clk);
    #1 op_valid = 1'b0;
    @(negedge clk);
    check("rssn3.ldi_after", acc, 16'h00AA);
    check("rssn3.rs0_after", rs0, 16'h0004);

    // Reset in the middle of a 5-step rotate.
    apply('{"pre_sa",  SA,  UL, 16'h0000, 0, 0, 16'h0000, 16'h0004, 16'h00AA, 16'h0004});
    apply('{"pre_ldi", LDI, UL, 16'h0005, 0, 0, 16'h0005, 16'h0004, 16'h00AA, 16'h0004});
    @(negedge clk);
    op_code = RSSN; rot_cnt = 4'd5; rs_sel = 2'd2; op_valid = 1'b1;
    @(posedge clk);
    #1 op_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_mid.busy_before", busy, 1);
    check("rst_mid.rs0_before", rs0, 16'h0002);
    #1 rst = 1'b0;
    #1;
    check("rst_mid.acc", acc, 0);
    check("rst_mid.rs0", rs0, 0);
    check("rst_mid.ra0", ra0, 0);
    check("rst_mid.rs2", rs_rd, 0);
    check("rst_mid.busy", busy, 0);
    check("rst_mid.ready", op_ready, 1);
    @(negedge clk);
    rst = 1'b1;
    apply('{"post_rst_ldi", LDI, LK8, 16'h003C, 0, 0, 16'h003C, 16'h0000, 16'h0000, 16'h0000});

    check("scoreboard_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/misao_regbank.md
Name: misao_regbank

Overview:
- Parametrised successor to the MISA-O management datapath: holds ACC, an RS swap bank of depth NS and an RA address bank of depth NA.
- Executes management ops (LDI, SS, RSS, RRS, RACC, SA, RSA) at a configurable link granularity, from nibble up to full width.
- Adds multi-cycle bank-rotate ops (RSSN/RSANN) behind a valid/ready handshake.
- Sits between the MISA-O decoder and the ALU/memory-address path.

Parameters:
- W, 16, datapath width in bits; multiple of 4, with W/4 a power of two.
- NS, 2, RS bank depth (>=2); RS0 is the swap target.
- NA, 2, RA bank depth (>=2); RA0 is the swap target.
- LW, $clog2($clog2(W/4)+1), width of the link field.
- CW, 4, width of the rotate count.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- op_valid  in  1  op present.
- op_ready  out  1  block can accept an op; equals !busy.
- op_code  in  4  opcode, from the misao_regbank_pkg enum.
- link  in  LW  slice size = 4<<link bits; 0=UL, 1=LK8, 2=LK16, ...
- imm  in  W  LDI immediate; only the low slice is used.
- rot_cnt  in  CW  step count for RSSN/RSANN.
- busy  out  1  a multi-cycle rotate is in progress.
- acc  out  W  accumulator.
- rs0  out  W  RS bank entry 0.
- ra0  out  W  RA bank entry 0.
- rs_sel  in  $clog2(NS)  debug read select.
- rs_rd  out  W  RS[rs_sel], combinational.

Behaviour:
- Reset (rst=0, async): ACC, all RS/RA entries, the step counter and busy go to 0 immediately; op_ready=1. Reset mid-rotate aborts the rotate with no partial state kept.
- Accept occurs when op_valid && op_ready. Single-cycle ops update state on the accepting edge; results are visible the next cycle.
- Slice S = 4<<link bits. If link encodes S > W, clamp to S = W.
- NOP: no state change.
- LDI: ACC[S-1:0] <= imm[S-1:0]; upper ACC bits are preserved.
- SS: swap ACC[S-1:0] with RS0[S-1:0]; upper bits of both are preserved.
- RRS: RS0 <= RS0 rotated right by S. No-op when S = W.
- RACC: ACC <= ACC rotated right by S. No-op when S = W.
- SA: full-width swap of ACC and RA0, independent of link.
- RSS: RS bank rotates down by one: RS0<=RS1, ..., RS[NS-1]<=RS0. For NS=2 this is a plain swap.
- RSA: same as RSS, applied to the RA bank.
- RSSN/RSANN, accepted with rot_cnt = N:
  - N = 0: complete like a NOP; busy is never asserted.
  - N > 0: busy=1 from the next cycle; one bank-rotate step per cycle for N cycles; busy drops after the Nth step.
  - Rotate counts >= depth are not reduced; they complete as N steps.
- While busy: op_ready=0 and op_valid is ignored. Only the bank being rotated changes; ACC and the other bank hold.
- Reserved opcodes act as NOP.
- No simultaneous-write hazards exist, since only one op is in flight.

Decomposition:
- misao_regbank_pkg holds:
  - the op_e enum: NOP=0, LDI, SS, RSS, RRS, RACC, SA, RSA, RSSN, RSANN, others reserved;
  - link constants UL=0, LK8=1, LK16=2;
  - function slice_mask(link, W);
  - function rotr_slice(value, link, W).
- One sub-module, misao_bank_rot: a generic depth-N ring register with a load-entry-0 port, a step input and an N-step counter/FSM (states IDLE, ROTATE). It is instantiated twice, once for RS and once for RA.

Test Plan:
- Reset, then LDI link=0 imm=5 -> ACC=0005. Then link=1 imm=00B3 -> ACC=00B3. Then link=2 imm=CAFE -> ACC=CAFE. Then link=1 imm=0091 -> ACC=CA91.
- From ACC=1357: SS link=2 -> ACC=0000, RS0=1357. Then RRS link=0 -> RS0=7135. Then ACC=A000, SS link=2 -> ACC=7135, RS0=A000. Then RACC link=1 on ACC=71D2 -> D271. Then RACC link=2 -> unchanged.
- SS link=0 with ACC=89A7, RS0=D271 -> ACC=89A1, RS0=D277. Then RSS (NS=2) -> RS0=0000, RS1=D277.
- With NS=4, RS={1,2,3,4}: RSSN rot_cnt=3 -> busy high exactly 3 cycles, op_ready low throughout, final RS0=4, RS1=1. An LDI presented during busy is ignored and is accepted after busy drops.
- SA link=0 with ACC=D27C, RA0=0 -> ACC=0000, RA0=D27C. Then RSA -> RA0=0000, RA1=D27C. RSANN rot_cnt=0 -> busy never asserted.
- Assert rst mid-RSSN (step 2 of 5) -> all outputs 0 within the same cycle, busy=0; the next op is accepted normally.
